// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - shared encodings for the RTC bus master and its bus-cycle sequencer
package rtc_bus_pkg;

    // Transaction-level FSM states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRE_CMD  = 3'd1;
    localparam logic [2:0] ST_ADDR     = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_POST_CMD = 3'd4;

    // Bus-cycle phases: setup, strobe pulse, hold, recovery
    localparam logic [1:0] PH_SU = 2'd0;
    localparam logic [1:0] PH_PW = 2'd1;
    localparam logic [1:0] PH_HD = 2'd2;
    localparam logic [1:0] PH_RC = 2'd3;

    // Bus-cycle kinds
    localparam logic [1:0] KIND_ADDR  = 2'd0;
    localparam logic [1:0] KIND_WDATA = 2'd1;
    localparam logic [1:0] KIND_RDATA = 2'd2;

    localparam logic [7:0] CMD_XFER_DEF = 8'hF0;

endpackage

// File: rtl/rtc_bus_cycle.sv
// rtl/rtc_bus_cycle.sv - one RTC bus cycle: SU/PW/HD/RC phase sequencer and strobe decode
module rtc_bus_cycle
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_SU = 2,
    parameter int unsigned T_PW = 4,
    parameter int unsigned T_HD = 2,
    parameter int unsigned T_RC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic [1:0] kind_i,
    output logic       cs_n_o,
    output logic       rd_n_o,
    output logic       wr_n_o,
    output logic       ad_sel_o,
    output logic       ad_oe_o,
    output logic       first_su_o,
    output logic       capture_o,
    output logic       done_o
);

    // Phase index 4 means "no further phase": the cycle ends
    localparam logic [2:0] PH_END = 3'd4;

    function automatic logic [7:0] ph_len(input logic [1:0] p);
        case (p)
            PH_SU:   ph_len = 8'(T_SU);
            PH_PW:   ph_len = 8'(T_PW);
            PH_HD:   ph_len = 8'(T_HD);
            default: ph_len = 8'(T_RC);
        endcase
    endfunction

    // Zero-length phases are skipped entirely, so T_HD=0 yields a three-phase cycle
    function automatic logic [2:0] skip_from(input logic [2:0] p);
        logic [2:0] r;
        r = PH_END;
        for (int k = 3; k >= 0; k--) begin
            if (k >= int'(p) && ph_len(2'(k)) != 8'd0) r = 3'(k);
        end
        return r;
    endfunction

    localparam logic [2:0] FIRST_PH = skip_from(3'd0);

    logic       active_q;
    logic [1:0] phase_q;
    logic [1:0] kind_q;
    logic [7:0] cnt_q;
    logic [2:0] next_ph;
    logic       last_clk;

    // Decode the last clock of the current phase and the phase that follows it
    always_comb begin
        next_ph  = skip_from({1'b0, phase_q} + 3'd1);
        last_clk = active_q && (cnt_q == ph_len(phase_q) - 8'd1);
    end

    // Phase/counter sequencing; a start on the final clock chains cycles back-to-back
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            phase_q  <= PH_SU;
            kind_q   <= KIND_ADDR;
            cnt_q    <= 8'd0;
        end else if (start_i) begin
            active_q <= 1'b1;
            phase_q  <= FIRST_PH[1:0];
            kind_q   <= kind_i;
            cnt_q    <= 8'd0;
        end else if (last_clk) begin
            if (next_ph == PH_END) begin
                active_q <= 1'b0;
            end else begin
                phase_q <= next_ph[1:0];
            end
            cnt_q <= 8'd0;
        end else if (active_q) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign cs_n_o     = !(active_q && phase_q != PH_RC);
    assign wr_n_o     = !(active_q && phase_q == PH_PW && kind_q != KIND_RDATA);
    assign rd_n_o     = !(active_q && phase_q == PH_PW && kind_q == KIND_RDATA);
    assign ad_sel_o   = active_q && kind_q != KIND_ADDR;
    assign ad_oe_o    = active_q && phase_q != PH_RC && kind_q != KIND_RDATA;
    assign first_su_o = active_q && phase_q == PH_SU && cnt_q == 8'd0;
    assign capture_o  = last_clk && phase_q == PH_PW && kind_q == KIND_RDATA;
    assign done_o     = last_clk && next_ph == PH_END;

endmodule

// File: rtl/rtc_bus_master.sv
// rtl/rtc_bus_master.sv - RTC bus master with bursts; RTC_CMD_AUTO_EN adds automatic 0xF0 command cycles
module rtc_bus_master
    import rtc_bus_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       LEN_W    = 4,
    parameter int unsigned       T_SU     = 2,
    parameter int unsigned       T_PW     = 4,
    parameter int unsigned       T_HD     = 2,
    parameter int unsigned       T_RC     = 2,
    parameter logic [DATA_W-1:0] CMD_XFER = CMD_XFER_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] wd_data,
    output logic              wd_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy,
    output logic              cs_n,
    output logic              rd_n,
    output logic              wr_n,
    output logic              ad_sel,
    output logic [DATA_W-1:0] ad_out,
    output logic              ad_oe,
    input  logic [DATA_W-1:0] ad_in
);

    logic [2:0]        state_q, state_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  beats_q, beats_d;
    logic [DATA_W-1:0] ad_out_q, ad_out_d;
    logic              rsp_valid_q, rsp_last_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic       cyc_start, cyc_first_su, cyc_capture, cyc_done;
    logic [1:0] cyc_kind;

    rtc_bus_cycle #(
        .T_SU(T_SU), .T_PW(T_PW), .T_HD(T_HD), .T_RC(T_RC)
    ) u_cycle (
        .clk       (clk),
        .reset     (reset),
        .start_i   (cyc_start),
        .kind_i    (cyc_kind),
        .cs_n_o    (cs_n),
        .rd_n_o    (rd_n),
        .wr_n_o    (wr_n),
        .ad_sel_o  (ad_sel),
        .ad_oe_o   (ad_oe),
        .first_su_o(cyc_first_su),
        .capture_o (cyc_capture),
        .done_o    (cyc_done)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = !req_ready;
    assign wd_ready  = cyc_first_su && state_q == ST_DATA && write_q;
    // wd_data is only guaranteed in its consume clock, so drive it straight through then
    assign ad_out    = wd_ready ? wd_data : ad_out_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;

    // Transaction sequencing: every state change into a bus state launches one bus cycle
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        addr_d    = addr_q;
        beats_d   = beats_q;
        ad_out_d  = ad_out_q;
        cyc_start = 1'b0;
        cyc_kind  = KIND_ADDR;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    beats_d = (req_len == '0) ? LEN_W'(1) : req_len;
`ifdef RTC_CMD_AUTO_EN
                    state_d = req_write ? ST_ADDR : ST_PRE_CMD;
`else
                    state_d = ST_ADDR;
`endif
                end
            end
            ST_PRE_CMD: if (cyc_done) state_d = ST_ADDR;
            ST_ADDR:    if (cyc_done) state_d = ST_DATA;
            ST_DATA: begin
                if (cyc_done) begin
                    addr_d  = addr_q + DATA_W'(1);
                    beats_d = beats_q - LEN_W'(1);
                    if (beats_q > LEN_W'(1)) begin
                        state_d = ST_ADDR;
                    end else begin
`ifdef RTC_CMD_AUTO_EN
                        state_d = write_q ? ST_POST_CMD : ST_IDLE;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
            end
            ST_POST_CMD: if (cyc_done) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        if (wd_ready) ad_out_d = wd_data;

        cyc_start = (state_d != state_q) && (state_d != ST_IDLE);
        if (state_d == ST_DATA) cyc_kind = write_d ? KIND_WDATA : KIND_RDATA;
        if (cyc_start) begin
            if (state_d == ST_ADDR) begin
                ad_out_d = addr_d;
            end else if (state_d != ST_DATA) begin
                ad_out_d = CMD_XFER;
            end
        end
    end

    // State registers and read-response pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            beats_q     <= '0;
            ad_out_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            beats_q     <= beats_d;
            ad_out_q    <= ad_out_d;
            rsp_valid_q <= cyc_capture;
            rsp_last_q  <= cyc_capture && (beats_q == LEN_W'(1));
            if (cyc_capture) rsp_data_q <= ad_in;
        end
    end

endmodule

// File: tb/tb_rtc_bus_master.sv
// tb/tb_rtc_bus_master.sv - directed self-checking bench for rtc_bus_master (default and short timing)
module tb_rtc_bus_master;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

`ifdef RTC_CMD_AUTO_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    // Instance A: default timing
    logic       req_valid_a = 1'b0, req_write_a = 1'b0;
    logic [7:0] req_addr_a = 8'h00;
    logic [3:0] req_len_a = 4'd0;
    logic [7:0] wd_data_a, rsp_data_a, ad_out_a, ad_in_a;
    logic       req_ready_a, wd_ready_a, rsp_valid_a, rsp_last_a, busy_a;
    logic       cs_n_a, rd_n_a, wr_n_a, ad_sel_a, ad_oe_a;

    // Instance B: T_SU=1, T_PW=1, T_HD=0, T_RC=1
    logic       req_valid_b = 1'b0, req_write_b = 1'b0;
    logic [7:0] req_addr_b = 8'h00;
    logic [3:0] req_len_b = 4'd0;
    logic [7:0] wd_data_b = 8'h00;
    logic [7:0] rsp_data_b, ad_out_b, ad_in_b;
    logic       req_ready_b, wd_ready_b, rsp_valid_b, rsp_last_b, busy_b;
    logic       cs_n_b, rd_n_b, wr_n_b, ad_sel_b, ad_oe_b;

    rtc_bus_master dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_write(req_write_a), .req_addr(req_addr_a), .req_len(req_len_a),
        .wd_data(wd_data_a), .wd_ready(wd_ready_a), .rsp_valid(rsp_valid_a),
        .rsp_data(rsp_data_a), .rsp_last(rsp_last_a), .busy(busy_a),
        .cs_n(cs_n_a), .rd_n(rd_n_a), .wr_n(wr_n_a), .ad_sel(ad_sel_a),
        .ad_out(ad_out_a), .ad_oe(ad_oe_a), .ad_in(ad_in_a)
    );

    rtc_bus_master #(.T_SU(1), .T_PW(1), .T_HD(0), .T_RC(1)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_write(req_write_b), .req_addr(req_addr_b), .req_len(req_len_b),
        .wd_data(wd_data_b), .wd_ready(wd_ready_b), .rsp_valid(rsp_valid_b),
        .rsp_data(rsp_data_b), .rsp_last(rsp_last_b), .busy(busy_b),
        .cs_n(cs_n_b), .rd_n(rd_n_b), .wr_n(wr_n_b), .ad_sel(ad_sel_b),
        .ad_out(ad_out_b), .ad_oe(ad_oe_b), .ad_in(ad_in_b)
    );

    // RTC register model: address cycles select a register, read strobes return it
    logic [7:0] mem [256];
    logic [7:0] rtc_addr_a = 8'h00, rtc_addr_b = 8'h00;
    assign ad_in_a = rd_n_a ? 8'h00 : mem[rtc_addr_a];
    assign ad_in_b = rd_n_b ? 8'h00 : mem[rtc_addr_b];

    // Write-data source, advanced on each consumed beat
    logic [7:0] wd_arr [8];
    int wd_idx = 0;
    assign wd_data_a = wd_arr[wd_idx];
    always @(posedge clk) if (wd_ready_a) wd_idx <= wd_idx + 1;

    int n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor for instance A
    logic [8:0] wlog[$], rlog[$], wrun_q[$], rrun_q[$], rsp_q[$];
    int   wrun = 0, rrun = 0, wd_cnt = 0, acc_cnt = 0;
    logic prev_wr = 1'b1, prev_rd = 1'b1, prev_busy = 1'b0;

    always @(negedge clk) begin
        if (!wr_n_a && prev_wr) wlog.push_back({ad_sel_a, ad_out_a});
        if (!rd_n_a && prev_rd) rlog.push_back({7'd0, ad_oe_a, ad_sel_a});
        if (!wr_n_a) wrun++;
        else if (wrun != 0) begin wrun_q.push_back(9'(wrun)); wrun = 0; end
        if (!rd_n_a) rrun++;
        else if (rrun != 0) begin rrun_q.push_back(9'(rrun)); rrun = 0; end
        if (!wr_n_a && !ad_sel_a && ad_out_a != 8'hF0) rtc_addr_a = ad_out_a;
        if (!wr_n_b && !ad_sel_b && ad_out_b != 8'hF0) rtc_addr_b = ad_out_b;
        if (rsp_valid_a) rsp_q.push_back({rsp_last_a, rsp_data_a});
        if (wd_ready_a) wd_cnt++;
        if (busy_a && !prev_busy) acc_cnt++;
        prev_wr = wr_n_a;
        prev_rd = rd_n_a;
        prev_busy = busy_a;
    end

    int wbase, rbase, wrbase, rrbase, rspbase, wd0, acc0;

    task automatic mark();
        wbase = wlog.size(); rbase = rlog.size(); wrbase = wrun_q.size();
        rrbase = rrun_q.size(); rspbase = rsp_q.size(); wd0 = wd_cnt; acc0 = acc_cnt;
    endtask

    task automatic check_log(input string tag, input logic [8:0] got[$], input int base,
                             input logic [8:0] exp[$]);
        check({tag, "_len"}, got.size() - base, exp.size());
        for (int i = 0; i < exp.size(); i++)
            if (base + i < got.size()) check($sformatf("%s[%0d]", tag, i), got[base + i], exp[i]);
    endtask

    task automatic run_a(input logic w, input logic [7:0] a, input logic [3:0] l, output int clks);
        mark();
        @(negedge clk);
        req_valid_a = 1'b1; req_write_a = w; req_addr_a = a; req_len_a = l;
        @(negedge clk);
        req_valid_a = 1'b0;
        clks = 0;
        while (busy_a && clks < 1000) begin clks++; @(negedge clk); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int clks, n, rsp_n;
        logic [8:0] exp[$], four[$], rsp_first, rsp_lastv;

        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5C;
        mem[8'h22] = 8'h10; mem[8'h23] = 8'h11; mem[8'h24] = 8'h12;
        wd_arr = '{8'h45, 8'hAA, 8'hBB, 8'h77, 8'h5A, 8'h00, 8'h00, 8'h00};
        four = '{9'h004, 9'h004, 9'h004, 9'h004};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cs_n", cs_n_a, 1); check("rst_rd_n", rd_n_a, 1); check("rst_wr_n", wr_n_a, 1);
        check("rst_ad_sel", ad_sel_a, 0); check("rst_ad_oe", ad_oe_a, 0); check("rst_ad_out", ad_out_a, 0);
        check("rst_req_ready", req_ready_a, 1); check("rst_busy", busy_a, 0);
        check("rst_wd_ready", wd_ready_a, 0); check("rst_rsp_valid", rsp_valid_a, 0);
        check("rst_rsp_last", rsp_last_a, 0); check("rst_rsp_data", rsp_data_a, 0);
        reset = 1'b0;

        // Single write 0x45 to 0x21
        run_a(1'b1, 8'h21, 4'd1, clks);
        exp = '{9'h021, 9'h145};
        if (AUTO) exp.push_back(9'h0F0);
        check_log("wr1_bus", wlog, wbase, exp);
        exp = four[0:(AUTO ? 2 : 1)];
        check_log("wr1_pw", wrun_q, wrbase, exp);
        check("wr1_clks", clks, AUTO ? 30 : 20);
        check("wr1_wd_ready", wd_cnt - wd0, 1);

        // Read burst of 3 from 0x22
        run_a(1'b0, 8'h22, 4'd3, clks);
        exp = '{9'h022, 9'h023, 9'h024};
        if (AUTO) exp.push_front(9'h0F0);
        check_log("rd3_addr", wlog, wbase, exp);
        exp = '{9'h001, 9'h001, 9'h001};
        check_log("rd3_oe_sel", rlog, rbase, exp);
        exp = four[0:2];
        check_log("rd3_pw", rrun_q, rrbase, exp);
        exp = '{9'h010, 9'h011, 9'h112};
        check_log("rd3_rsp", rsp_q, rspbase, exp);
        check("rd3_clks", clks, AUTO ? 70 : 60);

        // Write burst of 2 wrapping 0xFF -> 0x00
        run_a(1'b1, 8'hFF, 4'd2, clks);
        exp = '{9'h0FF, 9'h1AA, 9'h000, 9'h1BB};
        if (AUTO) exp.push_back(9'h0F0);
        check_log("wr2_bus", wlog, wbase, exp);
        check("wr2_clks", clks, AUTO ? 50 : 40);
        check("wr2_wd_ready", wd_cnt - wd0, 2);

        // Reset during the PW phase of a write data cycle
        @(negedge clk);
        req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 8'h30; req_len_a = 4'd1;
        @(negedge clk);
        req_valid_a = 1'b0;
        n = 0;
        while (!(!wr_n_a && ad_sel_a) && n < 100) begin n++; @(negedge clk); end
        check("mid_reach_data_pw", n < 100, 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_cs_n", cs_n_a, 1); check("mid_wr_n", wr_n_a, 1); check("mid_rd_n", rd_n_a, 1);
        check("mid_ad_oe", ad_oe_a, 0); check("mid_req_ready", req_ready_a, 1); check("mid_busy", busy_a, 0);
        reset = 1'b0;
        run_a(1'b0, 8'h22, 4'd0, clks);
        exp = '{9'h110};
        check_log("post_rst_rsp", rsp_q, rspbase, exp);
        check("post_rst_clks", clks, AUTO ? 30 : 20);

        // req_valid held while busy: one transaction, later address changes ignored
        mark();
        @(negedge clk);
        req_valid_a = 1'b1; req_write_a = 1'b1; req_addr_a = 8'h40; req_len_a = 4'd1;
        @(negedge clk);
        req_addr_a = 8'h99;
        repeat (14) @(negedge clk);
        req_valid_a = 1'b0;
        n = 0;
        while (busy_a && n < 1000) begin n++; @(negedge clk); end
        repeat (3) @(negedge clk);
        check("hold_accepts", acc_cnt - acc0, 1);
        exp = '{9'h040, 9'h15A};
        if (AUTO) exp.push_back(9'h0F0);
        check_log("hold_bus", wlog, wbase, exp);

        // Short timing on instance B: 3-clock cycles, 2-beat read from 0x23
        @(negedge clk);
        req_valid_b = 1'b1; req_write_b = 1'b0; req_addr_b = 8'h23; req_len_b = 4'd2;
        @(negedge clk);
        req_valid_b = 1'b0;
        clks = 0; n = 0; rsp_n = 0; rsp_first = '0; rsp_lastv = '0;
        while (busy_b && clks < 1000) begin
            clks++;
            if (!rd_n_b) n++;
            if (rsp_valid_b) begin
                if (rsp_n == 0) rsp_first = {rsp_last_b, rsp_data_b};
                rsp_lastv = {rsp_last_b, rsp_data_b};
                rsp_n++;
            end
            @(negedge clk);
        end
        check("short_clks", clks, AUTO ? 15 : 12);
        check("short_rd_low", n, 2);
        check("short_rsp_count", rsp_n, 2);
        check("short_rsp_first", rsp_first, 9'h011);
        check("short_rsp_last", rsp_lastv, 9'h112);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
